ipml_reg_fifo_ser_tx: RTL and testbench
=======================================

Name: ipml_reg_fifo_ser_tx

Overview:
- Transmit-side width serializer on the valid/ready stream interface used by the 2-entry register FIFOs in the capture path.
- Accepts one wide word of N*W bits and emits N narrow beats of W bits downstream, with a last-beat flag.
- Sits between the wide sample/FFT-bin stream and narrow consumers (byte UART/USB formatter).
- Sustains full throughput: a new wide word is accepted in the same cycle the final beat of the previous word is accepted.

Parameters:
- W, 8, width of one output beat in bits.
- N, 4, number of beats per input word; legal range 2..256.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- data_in_valid, input, 1, upstream word valid.
- data_in, input, W*N, upstream wide word.
- data_in_ready, output, 1, block can take a word this cycle.
- data_out_ready, input, 1, downstream accepts the current beat.
- data_out, output, W, current beat.
- data_out_valid, output, 1, beat valid.
- data_out_last, output, 1, current beat is the final beat of its word.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: data_out_valid=0, data_out_last=0, data_out=0, beat counter=0, holding register=0.
- Reset mid-word discards the remaining beats; no partial word is resumed.
- Handshakes:
  - wr = data_in_valid & data_in_ready.
  - rd = data_out_valid & data_out_ready.
- State: holding register hold[W*N-1:0], beat counter cnt (width clog2(N)), busy flag. busy is 1 while any beat of the held word is unsent; data_out_valid = busy.
- data_in_ready = ~busy | (rd & data_out_last). Combinational from data_out_ready, with no combinational path from data_in_valid.
- On wr: hold <= data_in, cnt <= 0, busy <= 1.
- Latency: word accepted at cycle t; beat 0 is valid at t+1.
- On rd with cnt != N-1: cnt <= cnt+1.
- On rd with cnt == N-1:
  - if wr in the same cycle, load the new word (cnt=0, busy stays 1);
  - otherwise busy <= 0 and cnt <= 0.
- data_out = hold[cnt*W +: W] (beat order LSB-first by default).
- data_out_last = busy & (cnt == N-1).
- Stall: while data_out_valid & ~data_out_ready, data_out, data_out_last and cnt hold stable. data_out_valid never drops without rd.
- Counter wraps only through the N-1 -> 0 rule above; it never exceeds N-1.
- data_in is ignored when data_in_ready=0.

Optional Feature:
- Macro: IPML_REG_FIFO_SER_TX_MSB_FIRST_EN.
- Defined: beat k = hold[(N-1-k)*W +: W], i.e. the most significant beat goes first.
- Undefined: LSB-first as above.
- Handshake, latency and data_out_last are identical in both builds.

Decomposition:
- Shared package/include holds:
  - clog2 constant function;
  - localparam CNT_W = clog2(N);
  - localparam DW = W*N.
- One sub-module is natural: ipml_reg_fifo_ser_beat_cnt.
  - Modulo-N counter with inc and clr inputs and an is_last output.
  - Reused by the future deserializer.
- The beat mux stays in the top level.

Test Plan:
- Single word, ready held 1:
  - stimulus: W=8, N=4, data_in=0x44332211 accepted at t;
  - required: beats 0x11,0x22,0x33,0x44 on t+1..t+4; last=1 only on 0x44; valid=0 at t+5.
- Back-to-back:
  - stimulus: words 0xA3A2A1A0 then 0xB3B2B1B0 offered continuously, ready=1;
  - required: 8 consecutive valid cycles with no bubble; data_in_ready=1 in the cycle 0xA3 is accepted.
- Backpressure:
  - stimulus: ready=0 for 3 cycles during beat 1 of 0x44332211;
  - required: data_out=0x22, last=0 stable; data_in_ready=0; 0x33 appears one cycle after ready returns.
- Reset mid-word:
  - stimulus: rst=1 for one cycle after beat 0x22 is accepted;
  - required: next cycle valid=0, last=0, data_out=0, data_in_ready=1; the next word starts at beat 0.
- MSB-first build:
  - stimulus: define IPML_REG_FIFO_SER_TX_MSB_FIRST_EN, input 0x44332211;
  - required: beats 0x44,0x33,0x22,0x11 with last on 0x11.
- Random valid/ready throttling, 1000 words, scoreboard:
  - required: every word reconstructs exactly, in order, with exactly one last per N beats.

Source files
------------

// File: rtl/ipml_reg_fifo_ser_tx_pkg.sv
// Shared definitions for the register-FIFO width serializer family.
// Default geometry and the constant log2 helper used to size beat counters.
package ipml_reg_fifo_ser_tx_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/ipml_reg_fifo_ser_beat_cnt.sv
// Modulo-N beat counter: clr wins over inc, inc wraps N-1 -> 0.
// Shared between the serializer and the matching deserializer.
module ipml_reg_fifo_ser_beat_cnt
  import ipml_reg_fifo_ser_tx_pkg::*;
#(
  parameter  int N     = DEF_N,
  localparam int CNT_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             is_last
);

  assign is_last = (cnt == CNT_W'(N - 1));

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= is_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ipml_reg_fifo_ser_tx.sv
// Wide-to-narrow valid/ready serializer: one W*N word out as N beats of W bits.
// Define IPML_REG_FIFO_SER_TX_MSB_FIRST_EN to send the most significant beat first.
module ipml_reg_fifo_ser_tx
  import ipml_reg_fifo_ser_tx_pkg::*;
#(
  parameter  int W     = DEF_W,
  parameter  int N     = DEF_N,
  localparam int CNT_W = clog2(N),
  localparam int DW    = W * N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_in_valid,
  input  logic [DW-1:0] data_in,
  output logic          data_in_ready,
  input  logic          data_out_ready,
  output logic [W-1:0]  data_out,
  output logic          data_out_valid,
  output logic          data_out_last
);

  logic [DW-1:0]    hold;
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sel;
  logic             is_last;
  logic             wr;
  logic             rd;

  assign rd             = busy & data_out_ready;
  // Accepting on the final beat keeps the stream gapless between words.
  assign data_in_ready  = ~busy | (rd & is_last);
  assign wr             = data_in_valid & data_in_ready;
  assign data_out_valid = busy;
  assign data_out_last  = busy & is_last;

  // NOTE: hold is a data register, yet it is reset so data_out reads zero
  // after reset instead of stale contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      busy <= 1'b0;
    end else if (wr) begin
      hold <= data_in;
      busy <= 1'b1;
    end else if (rd && is_last) begin
      busy <= 1'b0;
    end
  end

  // A load always restarts at beat 0; otherwise each accepted beat advances.
  ipml_reg_fifo_ser_beat_cnt #(
    .N (N)
  ) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (rd),
    .clr     (wr),
    .cnt     (cnt),
    .is_last (is_last)
  );

  // NOTE: combinational outputs get a default before any conditional code,
  // so no path can leave them unassigned and infer a latch.
  always_comb begin
    sel      = cnt;
    data_out = '0;
`ifdef IPML_REG_FIFO_SER_TX_MSB_FIRST_EN
    sel      = CNT_W'(N - 1) - cnt;
`else
    sel      = cnt;
`endif
    data_out = hold[int'(sel) * W +: W];
  end

endmodule

// File: tb/tb_ipml_reg_fifo_ser_tx.sv
// Directed and throttled-random checks of ipml_reg_fifo_ser_tx with W=8, N=4.
// Beat order expectations follow IPML_REG_FIFO_SER_TX_MSB_FIRST_EN when defined.
module tb_ipml_reg_fifo_ser_tx;

  localparam int W = 8;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_in_valid;
  logic [31:0]   data_in;
  logic          data_in_ready;
  logic          data_out_ready;
  logic [7:0]    data_out;
  logic          data_out_valid;
  logic          data_out_last;

  int total = 0;
  int bad   = 0;

  logic [7:0] tab [4];

  ipml_reg_fifo_ser_tx #(
    .W (W),
    .N (N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_in_ready  (data_in_ready),
    .data_out_ready (data_out_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_last  (data_out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat k of a word in transmit order.
  function automatic logic [7:0] exp_beat(input logic [31:0] word, input int k);
`ifdef IPML_REG_FIFO_SER_TX_MSB_FIRST_EN
    return word[(N - 1 - k) * W +: W];
`else
    return word[k * W +: W];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [31:0] q [$];
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] wd;
    int          bidx;
    int          words_in;
    int          words_out;
    int          cyc;
    logic        took;

`ifdef IPML_REG_FIFO_SER_TX_MSB_FIRST_EN
    tab = '{8'h44, 8'h33, 8'h22, 8'h11};
`else
    tab = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    wa = 32'hA3A2A1A0;
    wb = 32'hB3B2B1B0;
    wd = 32'hD3D2D1D0;

    // Reset state
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_in = '0;
    data_out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_last", 32'(data_out_last), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_in_ready", 32'(data_in_ready), 32'd1);

    // Single word, ready held high
    data_in = 32'h44332211;
    data_in_valid = 1'b1;
    settle();
    check("w1_in_ready", 32'(data_in_ready), 32'd1);
    step();
    data_in_valid = 1'b0;
    settle();
    for (int k = 0; k < N; k++) begin
      check($sformatf("w1_valid%0d", k), 32'(data_out_valid), 32'd1);
      check($sformatf("w1_data%0d", k), 32'(data_out), 32'(tab[k]));
      check($sformatf("w1_last%0d", k), 32'(data_out_last), 32'(k == N - 1));
      step();
      settle();
    end
    check("w1_idle", 32'(data_out_valid), 32'd0);

    // Back-to-back words with no bubble
    data_in = wa;
    data_in_valid = 1'b1;
    settle();
    check("b2b_a_ready", 32'(data_in_ready), 32'd1);
    step();
    data_in = wb;
    settle();
    for (int k = 0; k < 2 * N; k++) begin
      check($sformatf("b2b_valid%0d", k), 32'(data_out_valid), 32'd1);
      check($sformatf("b2b_data%0d", k), 32'(data_out),
            32'(exp_beat((k < N) ? wa : wb, k % N)));
      if (k < N - 1) check($sformatf("b2b_busy%0d", k), 32'(data_in_ready), 32'd0);
      if (k == N - 1) check("b2b_a3_ready", 32'(data_in_ready), 32'd1);
      step();
      if (k == N - 1) data_in_valid = 1'b0;
      settle();
    end
    check("b2b_idle", 32'(data_out_valid), 32'd0);

    // Backpressure during beat 1
    data_in = 32'h44332211;
    data_in_valid = 1'b1;
    settle();
    step();
    data_in_valid = 1'b0;
    settle();
    check("bp_beat0", 32'(data_out), 32'(tab[0]));
    step();
    data_out_ready = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_data%0d", i), 32'(data_out), 32'(tab[1]));
      check($sformatf("bp_last%0d", i), 32'(data_out_last), 32'd0);
      check($sformatf("bp_valid%0d", i), 32'(data_out_valid), 32'd1);
      check($sformatf("bp_in_ready%0d", i), 32'(data_in_ready), 32'd0);
      step();
      settle();
    end
    data_out_ready = 1'b1;
    settle();
    check("bp_release", 32'(data_out), 32'(tab[1]));
    step();
    settle();
    check("bp_beat2", 32'(data_out), 32'(tab[2]));
    step();
    settle();
    check("bp_beat3", 32'(data_out), 32'(tab[3]));
    check("bp_last3", 32'(data_out_last), 32'd1);
    step();
    settle();
    check("bp_idle", 32'(data_out_valid), 32'd0);

    // Reset mid-word after beat 1 is accepted
    data_in = 32'h44332211;
    data_in_valid = 1'b1;
    settle();
    step();
    data_in_valid = 1'b0;
    settle();
    step();
    settle();
    step();
    rst = 1'b1;
    settle();
    step();
    rst = 1'b0;
    settle();
    check("mid_rst_valid", 32'(data_out_valid), 32'd0);
    check("mid_rst_last", 32'(data_out_last), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_in_ready", 32'(data_in_ready), 32'd1);
    data_in = wd;
    data_in_valid = 1'b1;
    settle();
    step();
    data_in_valid = 1'b0;
    settle();
    check("mid_new_beat0", 32'(data_out), 32'(exp_beat(wd, 0)));
    check("mid_new_last0", 32'(data_out_last), 32'd0);
    for (int i = 0; i < N; i++) step();
    settle();
    check("mid_new_idle", 32'(data_out_valid), 32'd0);

    // Random valid/ready throttling with an in-order scoreboard
    bidx = 0;
    words_in = 0;
    words_out = 0;
    cyc = 0;
    data_in_valid = 1'b0;
    while (words_out < 1000 && cyc < 40000) begin
      if (!data_in_valid && words_in < 1000 && $urandom_range(0, 9) < 7) begin
        data_in = $urandom;
        data_in_valid = 1'b1;
      end
      data_out_ready = ($urandom_range(0, 3) != 0);
      settle();
      if (data_out_valid && data_out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 32'd1, 32'd0);
        end else begin
          check("rand_data", 32'(data_out), 32'(exp_beat(q[0], bidx)));
          check("rand_last", 32'(data_out_last), 32'(bidx == N - 1));
          if (bidx == N - 1) begin
            void'(q.pop_front());
            bidx = 0;
            words_out++;
          end else begin
            bidx++;
          end
        end
      end
      took = data_in_valid && data_in_ready;
      if (took) begin
        q.push_back(data_in);
        words_in++;
      end
      step();
      if (took) data_in_valid = 1'b0;
      cyc++;
    end
    check("rand_words", 32'(words_out), 32'd1000);
    check("rand_q_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
